// File: rtl/clk100_reset_seq_if.sv
// Status and control bundle for the 100 MHz reset sequencer.
// Inputs arrive asynchronously; every output is registered in the clk_i domain.
interface clk100_reset_seq_if;
  logic       lock_i;
  logic       soft_rst_i;
  logic       core_rst_o;
  logic       capture_rst_o;
  logic       ready_o;
  logic       lock_lost_o;
  logic [7:0] loss_count_o;
  logic [2:0] state_o;
  logic       heartbeat_o;

  modport master (
    output lock_i,
    output soft_rst_i,
    input  core_rst_o,
    input  capture_rst_o,
    input  ready_o,
    input  lock_lost_o,
    input  loss_count_o,
    input  state_o,
    input  heartbeat_o
  );

  modport slave (
    input  lock_i,
    input  soft_rst_i,
    output core_rst_o,
    output capture_rst_o,
    output ready_o,
    output lock_lost_o,
    output loss_count_o,
    output state_o,
    output heartbeat_o
  );
endinterface

// File: rtl/clk100_reset_seq.sv
// Reset sequencer for the 100 MHz capture domain: staged core/capture
// release after stable lock, lock-loss tracking and a RUN heartbeat.
module clk100_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CORE_TO_CAP_CYCLES = 16,
  parameter int LOSS_FILTER_CYCLES = 4,
  parameter int HEARTBEAT_DIV      = 50000000
) (
  input logic               clk_i,
  input logic               rst_ni,
  clk100_reset_seq_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    CORE_UP   = 3'd2,
    RUN       = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  localparam int LW =
    (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int XW =
    (CORE_TO_CAP_CYCLES > 1) ? $clog2(CORE_TO_CAP_CYCLES) : 1;
  localparam int CW = (LW > XW) ? LW : XW;
  localparam int FW =
    (LOSS_FILTER_CYCLES > 1) ? $clog2(LOSS_FILTER_CYCLES) : 1;
  localparam int HW =
    (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;

  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(CORE_TO_CAP_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(LOSS_FILTER_CYCLES - 1);
  localparam logic [HW-1:0] HB_LAST    = HW'(HEARTBEAT_DIV - 1);

  logic [SYNC_STAGES-1:0] lock_q;
  logic [SYNC_STAGES-1:0] soft_q;
  logic                   lock_s;
  logic                   soft_s;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [FW-1:0] filt;
  logic [FW-1:0] filt_n;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_n;
  logic          hb;
  logic          hb_n;
  logic          lost;
  logic          lost_n;
  logic [7:0]    lcnt;
  logic [7:0]    lcnt_n;
  logic          loss;
  logic          core_q;
  logic          cap_q;
  logic          ready_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= '0;
      soft_q <= '0;
    end else begin
      lock_q <= {lock_q[SYNC_STAGES-2:0], bus.lock_i};
      soft_q <= {soft_q[SYNC_STAGES-2:0], bus.soft_rst_i};
    end
  end

  assign lock_s = lock_q[SYNC_STAGES-1];
  assign soft_s = soft_q[SYNC_STAGES-1];

  // STABLE starts at 1: the WAIT_LOCK cycle that saw lock already counts.
  always_comb begin
    nxt    = state;
    cnt_n  = cnt;
    filt_n = '0;
    hcnt_n = '0;
    hb_n   = 1'b0;
    lost_n = lost;
    lcnt_n = lcnt;
    loss   = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (lock_s && !soft_s) begin
          if (LOCK_STABLE_CYCLES == 1) begin
            nxt = CORE_UP;
          end else begin
            nxt   = STABLE;
            cnt_n = CW'(1);
          end
        end
      end
      STABLE: begin
        if (!lock_s || soft_s) begin
          nxt   = WAIT_LOCK;
          cnt_n = '0;
        end else if (cnt == LOCK_LAST) begin
          nxt   = CORE_UP;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CORE_UP: begin
        if (!lock_s || soft_s) begin
          nxt   = DRAIN;
          cnt_n = '0;
        end else if (cnt == CAP_LAST) begin
          nxt   = RUN;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        loss = !lock_s && (filt == FILT_LAST);
        if (loss || soft_s) begin
          nxt   = DRAIN;
          cnt_n = '0;
        end else begin
          filt_n = lock_s ? '0 : filt + 1'b1;
          if (hcnt == HB_LAST) begin
            hb_n = !hb;
          end else begin
            hcnt_n = hcnt + 1'b1;
            hb_n   = hb;
          end
        end
        if (loss) begin
          lost_n = 1'b1;
          if (lcnt != 8'hFF) lcnt_n = lcnt + 8'd1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          nxt   = WAIT_LOCK;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        nxt   = WAIT_LOCK;
        cnt_n = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move with the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      filt    <= '0;
      hcnt    <= '0;
      hb      <= 1'b0;
      lost    <= 1'b0;
      lcnt    <= '0;
      core_q  <= 1'b1;
      cap_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_n;
      filt    <= filt_n;
      hcnt    <= hcnt_n;
      hb      <= hb_n;
      lost    <= lost_n;
      lcnt    <= lcnt_n;
      core_q  <= (nxt == WAIT_LOCK) || (nxt == STABLE) ||
                 (nxt == DRAIN);
      cap_q   <= (nxt != RUN);
      ready_q <= (nxt == RUN);
    end
  end

  assign bus.core_rst_o    = core_q;
  assign bus.capture_rst_o = cap_q;
  assign bus.ready_o       = ready_q;
  assign bus.lock_lost_o   = lost;
  assign bus.loss_count_o  = lcnt;
  assign bus.state_o       = state;
  assign bus.heartbeat_o   = hb;

endmodule

// File: doc/clk100_reset_seq.md
Name: clk100_reset_seq

Overview:
- Reset sequencer that runs in the 100 MHz capture clock domain produced by the board clock generator (12 MHz in, 100 MHz out).
- Consumes the generator's lock indication and a software reset request.
- Releases the core reset first, then the capture-path reset, each only after lock has been stable for a programmable time.
- Tracks lock-loss events, drives a status heartbeat, and forces a clean re-sequence whenever lock is lost.

Parameters:
- SYNC_STAGES, 2, flops in the lock_i / soft_rst_i synchronisers (minimum 2).
- LOCK_STABLE_CYCLES, 1024, synchronised-lock-high cycles required before core reset release (minimum 1).
- CORE_TO_CAP_CYCLES, 16, cycles between core reset release and capture reset release (minimum 1).
- LOSS_FILTER_CYCLES, 4, consecutive synchronised-lock-low cycles that count as a lock loss once in RUN (minimum 1).
- HEARTBEAT_DIV, 50000000, heartbeat half-period in cycles (minimum 1).

Ports:
- clk_i  in  1  100 MHz clock from clock generator output buffer.
- rst_ni  in  1  asynchronous active-low reset.
- lock_i  in  1  clock generator lock; asynchronous to clk_i.
- soft_rst_i  in  1  software reset request, level; asynchronous to clk_i.
- core_rst_o  out  1  active-high reset to core logic.
- capture_rst_o  out  1  active-high reset to capture logic.
- ready_o  out  1  high only in RUN.
- lock_lost_o  out  1  sticky; set on the first lock loss; cleared only by rst_ni.
- loss_count_o  out  8  lock-loss event count; saturates at 255.
- state_o  out  3  current state encoding.
- heartbeat_o  out  1  toggles every HEARTBEAT_DIV cycles while in RUN.

Behaviour:
- Reset: rst_ni low asynchronously forces:
  - state WAIT_LOCK, core_rst_o=1, capture_rst_o=1, ready_o=0.
  - lock_lost_o=0, loss_count_o=0, heartbeat_o=0, all counters 0, synchronisers 0.
- Deassertion of rst_ni takes effect on the next clk_i edge. The assertion of core_rst_o / capture_rst_o is therefore asynchronous; their release is synchronous to clk_i.
- lock_s and soft_s are the SYNC_STAGES-deep synchronised versions of lock_i and soft_rst_i. All decisions use these; latency from input to lock_s/soft_s is SYNC_STAGES cycles.
- States and encoding: WAIT_LOCK=0, STABLE=1, CORE_UP=2, RUN=3, DRAIN=4.
- WAIT_LOCK:
  - Both resets asserted; counter cleared.
  - Go to STABLE when lock_s=1 and soft_s=0.
- STABLE:
  - Both resets asserted; counter increments each cycle.
  - lock_s=0 or soft_s=1 -> WAIT_LOCK, counter cleared. This is not counted as a loss.
  - When the counter reaches LOCK_STABLE_CYCLES-1 -> CORE_UP, counter cleared.
  - Net effect: core_rst_o falls exactly LOCK_STABLE_CYCLES cycles after the first lock_s=1 cycle.
- CORE_UP:
  - core_rst_o=0, capture_rst_o=1; counter increments.
  - At CORE_TO_CAP_CYCLES-1 -> RUN.
  - lock_s=0 or soft_s=1 -> DRAIN immediately.
- RUN:
  - Both resets 0; ready_o=1; heartbeat counter runs.
  - Loss filter counts consecutive lock_s=0 cycles. Any lock_s=1 cycle clears it, so glitches shorter than LOSS_FILTER_CYCLES are ignored.
  - Filter reaching LOSS_FILTER_CYCLES -> DRAIN, lock_lost_o<=1, loss_count_o increments (saturating).
  - soft_s=1 -> DRAIN with no loss accounting.
  - If soft_s=1 and the filter threshold occur in the same cycle, the loss is still counted.
- DRAIN:
  - core_rst_o=1 and capture_rst_o=1 from the first DRAIN cycle; ready_o=0; heartbeat_o forced to 0.
  - Stays for exactly 2 cycles, then -> WAIT_LOCK.
  - This guarantees a minimum 3-cycle reset pulse, including the WAIT_LOCK cycle.
- Outputs are registered and decoded from the next state, so they change in the same cycle the state changes.
- Heartbeat counter and loss filter are cleared on any exit from RUN.
- Counters are sized to clog2 of their parameter, minimum 1 bit. Wrap-around is never reachable because every counter is cleared at its terminal value.
- soft_s held high keeps the block in WAIT_LOCK indefinitely.

Test Plan:
- Basic sequencing: LOCK_STABLE_CYCLES=8, CORE_TO_CAP_CYCLES=4, SYNC_STAGES=2. Release rst_ni, raise lock_i at cycle 10 -> core_rst_o falls at cycle 20, capture_rst_o and ready_o at cycle 24; state_o sequence 0,1,2,3.
- Lock bounce in STABLE: lock_i low for 1 cycle at 5 cycles into STABLE -> return to WAIT_LOCK, full 8-cycle count restarts, loss_count_o stays 0.
- Glitch filter: LOSS_FILTER_CYCLES=4. In RUN, lock_i low 3 cycles -> stays RUN. Lock_i low 4 cycles -> DRAIN, resets high 2 cycles, lock_lost_o=1, loss_count_o=1, then re-sequence once lock returns.
- Soft reset: pulse soft_rst_i for 1 cycle in RUN -> DRAIN, then WAIT_LOCK, then a full re-sequence; lock_lost_o stays 0 and loss_count_o is unchanged.
- Saturation and heartbeat: 300 forced losses -> loss_count_o=255. With HEARTBEAT_DIV=5 in RUN, heartbeat_o toggles every 5 cycles and is 0 in any non-RUN state.
- Async reset mid-RUN: assert rst_ni between clock edges -> core_rst_o and capture_rst_o go 1 before the next edge; every other output returns to its reset value.
